// File: rtl/noc_traffic_engine.sv
// NoC traffic engine: per-port packet generators (random, fixed or round-robin
// destination) and per-port sinks that count deliveries and flag misroutes.
module noc_traffic_engine #(
    parameter int          NUM_PORTS = 13,
    parameter int          WIDTH     = 33,
    parameter int          DEST_W    = 4,
    parameter int          DEST_LSB  = 29,
    parameter int          SEQ_W     = 16,
    parameter int          GAP       = 0,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic [DEST_W-1:0]             fixed_dest,
    input  logic                          excl_self,
    input  logic [SEQ_W-1:0]              num_pkts,
    output logic [NUM_PORTS*WIDTH-1:0]    tx_data,
    output logic [NUM_PORTS-1:0]          tx_valid,
    input  logic [NUM_PORTS-1:0]          tx_ready,
    input  logic [NUM_PORTS*WIDTH-1:0]    rx_data,
    input  logic [NUM_PORTS-1:0]          rx_valid,
    output logic [NUM_PORTS-1:0]          rx_ready,
    output logic [NUM_PORTS*SEQ_W-1:0]    tx_count,
    output logic [NUM_PORTS*SEQ_W-1:0]    rx_count,
    output logic [NUM_PORTS-1:0]          err,
    output logic [SEQ_W-1:0]              err_count,
    output logic                          all_done
);

    typedef enum logic [1:0] {IDLE, SEND, GAPWAIT, DONE} gen_state_e;

    localparam int PAD    = WIDTH - 2*DEST_W - SEQ_W;
    localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int MISS_W = $clog2(NUM_PORTS + 1);
    localparam int SUM_W  = SEQ_W + MISS_W;
    localparam logic [SEQ_W-1:0] CNT_MAX = '1;

    function automatic logic [15:0] seed_of(input int i);
        return SEED ^ 16'(i + 1);
    endfunction

    // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [DEST_W-1:0] first_rr(input int i);
        return DEST_W'((i + 1) % NUM_PORTS);
    endfunction

    function automatic logic [DEST_W-1:0] wrap_inc(input logic [DEST_W-1:0] d);
        return (int'(d) == NUM_PORTS - 1) ? '0 : d + 1'b1;
    endfunction

    function automatic logic [SEQ_W-1:0] sat_inc(input logic [SEQ_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    function automatic logic [DEST_W-1:0] dest_of(
        input int                i,
        input logic [1:0]        m,
        input logic [DEST_W-1:0] fixed,
        input logic              excl,
        input logic [15:0]       lfsr,
        input logic [DEST_W-1:0] rr
    );
        logic [DEST_W-1:0] raw;
        case (m)
            2'd1:    raw = DEST_W'(int'(fixed) % NUM_PORTS);
            2'd2:    raw = rr;
            default: raw = DEST_W'(int'(lfsr[7:0]) % NUM_PORTS);
        endcase
        if (excl && int'(raw) == i) raw = DEST_W'((i + 1) % NUM_PORTS);
        return raw;
    endfunction

    gen_state_e         state_q   [NUM_PORTS], state_d   [NUM_PORTS];
    logic [SEQ_W-1:0]   seq_q     [NUM_PORTS], seq_d     [NUM_PORTS];
    logic [15:0]        lfsr_q    [NUM_PORTS], lfsr_d    [NUM_PORTS];
    logic [DEST_W-1:0]  rr_q      [NUM_PORTS], rr_d      [NUM_PORTS];
    logic [GAP_W-1:0]   gap_q     [NUM_PORTS], gap_d     [NUM_PORTS];
    logic [SEQ_W-1:0]   tx_cnt_q  [NUM_PORTS], tx_cnt_d  [NUM_PORTS];
    logic [SEQ_W-1:0]   rx_cnt_q  [NUM_PORTS], rx_cnt_d  [NUM_PORTS];
    logic [DEST_W-1:0]  dest      [NUM_PORTS];
    logic [NUM_PORTS-1:0] err_q, err_d;
    logic [SEQ_W-1:0]   err_count_q, err_count_d;
    logic               all_done_q, all_done_d;
    logic [1:0]         mode_q, mode_d;
    logic [DEST_W-1:0]  fixed_dest_q, fixed_dest_d;
    logic               excl_self_q, excl_self_d;
    logic [SEQ_W-1:0]   num_pkts_q, num_pkts_d;
    logic               launch, busy, all_fin;
    logic [SUM_W-1:0]   tx_sum, rx_sum;
    logic [MISS_W-1:0]  miss_cnt;
    logic [SEQ_W:0]     err_sum;
    logic               unused_rx;

    // A run only launches when no generator is mid-run; start is ignored otherwise.
    always_comb begin
        busy    = 1'b0;
        all_fin = 1'b1;
        tx_sum  = '0;
        rx_sum  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            busy    |= (state_q[i] == SEND) || (state_q[i] == GAPWAIT);
            all_fin &= (state_q[i] == DONE);
            tx_sum  += SUM_W'(tx_cnt_q[i]);
            rx_sum  += SUM_W'(rx_cnt_q[i]);
        end
        launch     = start && !busy;
        all_done_d = !launch && all_fin && (tx_sum == rx_sum);
    end

    always_comb begin
        tx_data  = '0;
        tx_valid = '0;
        tx_count = '0;
        rx_count = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            dest[i]     = dest_of(i, mode_q, fixed_dest_q, excl_self_q, lfsr_q[i], rr_q[i]);
            tx_valid[i] = (state_q[i] == SEND);
            tx_data[i*WIDTH +: WIDTH] = tx_valid[i]
                ? (WIDTH'({dest[i], DEST_W'(i), seq_q[i]}) << PAD) : '0;
            tx_count[i*SEQ_W +: SEQ_W] = tx_cnt_q[i];
            rx_count[i*SEQ_W +: SEQ_W] = rx_cnt_q[i];
        end
    end

    // NOTE: every _d signal gets its hold value first, so no path through this
    // block can leave one unassigned and infer a latch.
    always_comb begin
        mode_d       = mode_q;
        fixed_dest_d = fixed_dest_q;
        excl_self_d  = excl_self_q;
        num_pkts_d   = num_pkts_q;
        if (launch) begin
            mode_d       = mode;
            fixed_dest_d = fixed_dest;
            excl_self_d  = excl_self;
            num_pkts_d   = num_pkts;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            state_d[i]  = state_q[i];
            seq_d[i]    = seq_q[i];
            lfsr_d[i]   = lfsr_q[i];
            rr_d[i]     = rr_q[i];
            gap_d[i]    = gap_q[i];
            tx_cnt_d[i] = tx_cnt_q[i];
            if (launch) begin
                state_d[i]  = SEND;
                seq_d[i]    = '0;
                lfsr_d[i]   = seed_of(i);
                rr_d[i]     = first_rr(i);
                gap_d[i]    = '0;
                tx_cnt_d[i] = '0;
            end else begin
                case (state_q[i])
                    SEND: begin
                        if (tx_ready[i]) begin
                            seq_d[i]    = seq_q[i] + 1'b1;
                            lfsr_d[i]   = lfsr_step(lfsr_q[i]);
                            rr_d[i]     = wrap_inc(rr_q[i]);
                            tx_cnt_d[i] = sat_inc(tx_cnt_q[i]);
                            if (num_pkts_q != '0 && tx_cnt_d[i] == num_pkts_q) begin
                                state_d[i] = DONE;
                            end else if (GAP == 0) begin
                                state_d[i] = SEND;
                            end else begin
                                state_d[i] = GAPWAIT;
                                gap_d[i]   = GAP_W'(GAP - 1);
                            end
                        end
                    end
                    GAPWAIT: begin
                        if (gap_q[i] == '0) state_d[i] = SEND;
                        else                gap_d[i]   = gap_q[i] - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Several sinks can misroute in the same cycle; all of them are added at once.
    always_comb begin
        miss_cnt = '0;
        err_d    = err_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rx_cnt_d[i] = rx_cnt_q[i];
            if (launch) begin
                rx_cnt_d[i] = '0;
                err_d[i]    = 1'b0;
            end else if (rx_valid[i]) begin
                rx_cnt_d[i] = sat_inc(rx_cnt_q[i]);
                if (rx_data[i*WIDTH + DEST_LSB +: DEST_W] != DEST_W'(i)) begin
                    err_d[i] = 1'b1;
                    miss_cnt = miss_cnt + 1'b1;
                end
            end
        end
        err_sum     = {1'b0, err_count_q} + (SEQ_W + 1)'(miss_cnt);
        err_count_d = launch ? '0 : (err_sum[SEQ_W] ? CNT_MAX : err_sum[SEQ_W-1:0]);
    end

    // NOTE: the per-port arrays are plain flops, not RAM, so resetting every
    // entry (including reseeding the LFSRs) is intended.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i]  <= IDLE;
                seq_q[i]    <= '0;
                lfsr_q[i]   <= seed_of(i);
                rr_q[i]     <= first_rr(i);
                gap_q[i]    <= '0;
                tx_cnt_q[i] <= '0;
                rx_cnt_q[i] <= '0;
            end
            err_q        <= '0;
            err_count_q  <= '0;
            all_done_q   <= 1'b0;
            mode_q       <= '0;
            fixed_dest_q <= '0;
            excl_self_q  <= 1'b0;
            num_pkts_q   <= '0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            lfsr_q       <= lfsr_d;
            rr_q         <= rr_d;
            gap_q        <= gap_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            all_done_q   <= all_done_d;
            mode_q       <= mode_d;
            fixed_dest_q <= fixed_dest_d;
            excl_self_q  <= excl_self_d;
            num_pkts_q   <= num_pkts_d;
        end
    end

    assign rx_ready  = {NUM_PORTS{~reset}};
    assign err       = err_q;
    assign err_count = err_count_q;
    assign all_done  = all_done_q;
    assign unused_rx = ^rx_data;

endmodule

// File: tb/tb_noc_traffic_engine.sv
// Directed bench for noc_traffic_engine: receive-side vector table plus
// hand-written multi-cycle sequences for generator behaviour.
module tb_noc_traffic_engine;

    localparam int N  = 13;
    localparam int W  = 33;
    localparam int SW = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int         port;
        logic [3:0] dest;
        logic       exp_err;
        int         exp_ecnt;
        int         exp_rxc;
    } rx_vec_t;

    logic            clk = 1'b0;
    logic            reset, start, excl_self;
    logic [1:0]      mode;
    logic [3:0]      fixed_dest;
    logic [SW-1:0]   num_pkts;
    logic [N*W-1:0]  tx_data, rx_data;
    logic [N-1:0]    tx_valid, tx_ready, rx_valid, rx_ready, err;
    logic [N*SW-1:0] tx_count, rx_count;
    logic [SW-1:0]   err_count;
    logic            all_done;

    logic [N*W-1:0]  g_tx_data;
    logic [N-1:0]    g_tx_valid, g_rx_ready, g_err;
    logic [N*SW-1:0] g_tx_count, g_rx_count;
    logic [SW-1:0]   g_err_count;
    logic            g_all_done;

    int n_vec = 0;
    int n_err = 0;
    bit noc_en = 1'b0;
    logic [W-1:0] sinkq [N][$];

    always #5 clk = ~clk;

    noc_traffic_engine dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .fixed_dest(fixed_dest),
        .excl_self(excl_self), .num_pkts(num_pkts), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_count(tx_count), .rx_count(rx_count), .err(err), .err_count(err_count),
        .all_done(all_done)
    );

    noc_traffic_engine #(.GAP(2)) dut_gap (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .fixed_dest(fixed_dest),
        .excl_self(excl_self), .num_pkts(num_pkts), .tx_data(g_tx_data), .tx_valid(g_tx_valid),
        .tx_ready({N{1'b1}}), .rx_data({N*W{1'b0}}), .rx_valid({N{1'b0}}), .rx_ready(g_rx_ready),
        .tx_count(g_tx_count), .rx_count(g_rx_count), .err(g_err), .err_count(g_err_count),
        .all_done(g_all_done)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] txd(input int p);
        return tx_data[p*W +: W];
    endfunction

    function automatic logic [3:0] txdest(input int p);
        logic [W-1:0] pkt;
        pkt = tx_data[p*W +: W];
        return pkt[32:29];
    endfunction

    function automatic logic [SW-1:0] txc(input int p);
        return tx_count[p*SW +: SW];
    endfunction

    function automatic logic [SW-1:0] rxc(input int p);
        return rx_count[p*SW +: SW];
    endfunction

    // Reference destination for mode 0: k-th packet of port p.
    function automatic logic [3:0] model_rand(input int p, input int k, input bit ex);
        logic [15:0] s;
        int d;
        s = SEED ^ 16'(p + 1);
        for (int j = 0; j < k; j++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        d = int'(s[7:0]) % N;
        if (ex && d == p) d = (p + 1) % N;
        return 4'(d);
    endfunction

    function automatic logic [3:0] model_rr(input int p, input int k, input bit ex);
        int d;
        d = (p + 1 + k) % N;
        if (ex && d == p) d = (p + 1) % N;
        return 4'(d);
    endfunction

    // Simple network: every sink drains one queued packet per cycle.
    task automatic noc_step();
        logic [W-1:0] pkt;
        int d;
        rx_valid = '0;
        rx_data  = '0;
        for (int s = 0; s < N; s++) begin
            if (sinkq[s].size() > 0) begin
                rx_valid[s] = 1'b1;
                rx_data[s*W +: W] = sinkq[s].pop_front();
            end
        end
        for (int p = 0; p < N; p++) begin
            if (tx_valid[p] && tx_ready[p]) begin
                pkt = tx_data[p*W +: W];
                d = int'(pkt[32:29]);
                if (d < N) sinkq[d].push_back(pkt);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (noc_en) noc_step();
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = '0;
        rx_data  = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic launch_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rx_vec_t rx_tab [6];
        logic [W-1:0] pkt_hold;
        logic [W-1:0] exp_pkt;
        logic [3:0]   run1_d0 [6];
        logic [3:0]   run1_d7 [6];
        int cyc;
        int others;

        rx_tab[0] = '{port: 4,  dest: 4'd4,  exp_err: 1'b0, exp_ecnt: 0, exp_rxc: 1};
        rx_tab[1] = '{port: 4,  dest: 4'd7,  exp_err: 1'b1, exp_ecnt: 1, exp_rxc: 2};
        rx_tab[2] = '{port: 4,  dest: 4'd4,  exp_err: 1'b1, exp_ecnt: 1, exp_rxc: 3};
        rx_tab[3] = '{port: 0,  dest: 4'd0,  exp_err: 1'b0, exp_ecnt: 1, exp_rxc: 1};
        rx_tab[4] = '{port: 12, dest: 4'd3,  exp_err: 1'b1, exp_ecnt: 2, exp_rxc: 1};
        rx_tab[5] = '{port: 9,  dest: 4'd15, exp_err: 1'b1, exp_ecnt: 3, exp_rxc: 1};

        reset = 1'b1; start = 1'b0; mode = 2'd0; fixed_dest = '0; excl_self = 1'b0;
        num_pkts = '0; tx_ready = '0; rx_valid = '0; rx_data = '0;
        tick();
        tick();
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_all_done", all_done, 0);
        check("rst_tx_count", |tx_count, 0);
        reset = 1'b0;
        tick();
        check("rx_ready_after_rst", rx_ready, {N{1'b1}});
        check("idle_no_valid", tx_valid, 0);

        // Receive-side table: sticky err and saturating misroute count.
        for (int v = 0; v < 6; v++) begin
            rx_valid = '0;
            rx_data  = '0;
            rx_valid[rx_tab[v].port] = 1'b1;
            rx_data[rx_tab[v].port*W +: W] = {rx_tab[v].dest, 4'(v), 16'(v * 7 + 1), 9'd0};
            tick();
            rx_valid = '0;
            check($sformatf("rxtab%0d_err", v), err[rx_tab[v].port], rx_tab[v].exp_err);
            check($sformatf("rxtab%0d_ecnt", v), err_count, rx_tab[v].exp_ecnt);
            check($sformatf("rxtab%0d_rxc", v), rxc(rx_tab[v].port), rx_tab[v].exp_rxc);
        end
        rx_valid = 3'b110;
        rx_data  = '0;
        tick();
        rx_valid = '0;
        check("dual_miss_ecnt", err_count, 5);
        tick(); tick(); tick();
        check("err_persist", err, 13'h1216);
        check("ecnt_persist", err_count, 5);

        // Start clears sink state; fixed_dest wraps mod N; excl_self redirects.
        mode = 2'd1; fixed_dest = 4'd14; excl_self = 1'b1; num_pkts = 16'd1;
        tx_ready = '1;
        launch_run();
        check("start_clears_err", err, 0);
        check("start_clears_ecnt", err_count, 0);
        check("start_clears_rxc", rxc(4), 0);
        check("fixed_mod_p0", txdest(0), 1);
        check("fixed_excl_p1", txdest(1), 2);
        check("fixed_mod_p5", txdest(5), 1);
        tick();
        tick();
        check("one_pkt_done_valid", tx_valid, 0);
        check("one_pkt_txc", txc(0), 1);
        check("unbalanced_not_done", all_done, 0);

        // Fixed destination 5 with a loopback network into sink 5.
        do_reset();
        mode = 2'd1; fixed_dest = 4'd5; excl_self = 1'b0; num_pkts = 16'd3;
        tx_ready = '1;
        for (int s = 0; s < N; s++) sinkq[s].delete();
        noc_en = 1'b1;
        launch_run();
        exp_pkt = {4'd5, 4'd2, 16'd0, 9'd0};
        check("pkt_layout_p2", txd(2), exp_pkt);
        cyc = 0;
        while (!all_done && cyc < 200) begin
            tick();
            cyc++;
        end
        noc_en = 1'b0;
        rx_valid = '0;
        check("loop_done_in_time", cyc < 200, 1);
        for (int p = 0; p < N; p++) check($sformatf("loop_txc%0d", p), txc(p), 3);
        check("loop_rxc5", rxc(5), 39);
        others = 0;
        for (int p = 0; p < N; p++) if (p != 5) others += int'(rxc(p));
        check("loop_rx_others", others, 0);
        check("loop_err", err, 0);
        check("loop_all_done", all_done, 1);

        // Round-robin with self-exclusion.
        do_reset();
        mode = 2'd2; excl_self = 1'b1; num_pkts = 16'd14; tx_ready = '1;
        launch_run();
        for (int k = 0; k < 14; k++) begin
            check($sformatf("rr_p12_k%0d", k), txdest(12), model_rr(12, k, 1'b1));
            check($sformatf("rr_p0_k%0d", k), txdest(0), model_rr(0, k, 1'b1));
            check($sformatf("rr_p0_notself_k%0d", k), txdest(0) == 4'd0, 0);
            tick();
        end
        check("rr_done_valid", tx_valid, 0);
        check("rr_txc12", txc(12), 14);

        // Backpressure on port 3; start while running must be ignored.
        do_reset();
        mode = 2'd0; excl_self = 1'b0; num_pkts = '0;
        tx_ready = '1;
        tx_ready[3] = 1'b0;
        launch_run();
        pkt_hold = txd(3);
        check("bp_first_dest", txdest(3), model_rand(3, 0, 1'b0));
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("bp_hold_k%0d", k), txd(3), pkt_hold);
        end
        check("bp_valid_held", tx_valid[3], 1);
        check("bp_txc_held", txc(3), 0);
        tx_ready[3] = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bp_one_xfer", txc(3), 1);
        check("bp_next_seq", txd(3) >> 9, {model_rand(3, 1, 1'b0), 4'd3, 16'd1});
        check("start_ignored_txc0", txc(0), 11);

        // GAP=2 instance: valid pattern 1,0,0,1,0,0.
        do_reset();
        mode = 2'd0; num_pkts = '0;
        launch_run();
        for (int k = 0; k < 6; k++) begin
            check($sformatf("gap_valid_k%0d", k), g_tx_valid[0], (k % 3) == 0);
            check($sformatf("gap_txc_k%0d", k), g_tx_count[SW-1:0], (k + 2) / 3);
            tick();
        end

        // Reset mid-run, then replay of the LFSR destination sequence.
        do_reset();
        mode = 2'd0; excl_self = 1'b0; num_pkts = '0; tx_ready = '1;
        launch_run();
        for (int k = 0; k < 6; k++) begin
            run1_d0[k] = txdest(0);
            run1_d7[k] = txdest(7);
            check($sformatf("rand_p0_k%0d", k), run1_d0[k], model_rand(0, k, 1'b0));
            check($sformatf("rand_p7_k%0d", k), run1_d7[k], model_rand(7, k, 1'b0));
            tick();
        end
        reset = 1'b1;
        start = 1'b1;
        rx_valid = '0;
        rx_valid[2] = 1'b1;
        rx_data[2*W +: W] = {4'd9, 29'd0};
        tick();
        check("midrst_valid", tx_valid, 0);
        check("midrst_data", |tx_data, 0);
        check("midrst_txc", |tx_count, 0);
        check("midrst_rxc", |rx_count, 0);
        check("midrst_err", err, 0);
        check("midrst_ecnt", err_count, 0);
        check("midrst_rx_ready", rx_ready, 0);
        check("midrst_all_done", all_done, 0);
        reset = 1'b0;
        start = 1'b0;
        rx_valid = '0;
        rx_data = '0;
        tick();
        check("rst_beats_start", tx_valid, 0);
        launch_run();
        for (int k = 0; k < 6; k++) begin
            check($sformatf("replay_p0_k%0d", k), txdest(0), run1_d0[k]);
            check($sformatf("replay_p7_k%0d", k), txdest(7), run1_d7[k]);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/noc_traffic_engine.md
NOC_TRAFFIC_ENGINE -- requirements
Module: noc_traffic_engine

Interface
REQ-001 Parameter NUM_PORTS, default 13, number of PM ports driven and sunk.
REQ-002 Parameter WIDTH, default 33, packet width.
REQ-003 Parameter DEST_W, default 4; DEST_LSB, default 29; destination field = pkt[DEST_LSB+DEST_W-1:DEST_LSB].
REQ-004 Parameter SEQ_W, default 16, sequence-number and counter width.
REQ-005 Parameter GAP, default 0, idle cycles inserted after each accepted packet per port.
REQ-006 Parameter SEED, default 16'hACE1, LFSR base seed.
REQ-007 clk  input  1  sole clock, all logic on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 start  input  1  one-cycle pulse launching a traffic run.
REQ-010 mode  input  2  0 = random, 1 = fixed destination, 2 = round-robin, 3 = reserved (behaves as 0).
REQ-011 fixed_dest  input  DEST_W  destination used in mode 1.
REQ-012 excl_self  input  1  1 = a port never addresses itself.
REQ-013 num_pkts  input  SEQ_W  packets per port per run; 0 = unlimited.
REQ-014 tx_data  output  NUM_PORTS*WIDTH  packet of port i in slice i.
REQ-015 tx_valid / tx_ready  output / input  NUM_PORTS  per-port send handshake.
REQ-016 rx_data  input  NUM_PORTS*WIDTH  delivered packet at sink i.
REQ-017 rx_valid / rx_ready  input / output  NUM_PORTS  per-port receive handshake.
REQ-018 tx_count / rx_count  output  NUM_PORTS*SEQ_W  per-port accepted-packet counters, saturating.
REQ-019 err  output  NUM_PORTS  sticky misroute flag per sink; err_count  output  SEQ_W  total misroutes, saturating.
REQ-020 all_done  output  1  every generator finished and sum(rx_count) == sum(tx_count).

Function
REQ-021 Packet layout SHALL be {dest, src (DEST_W), seq (SEQ_W), zeros}, MSB first from WIDTH-1.
REQ-022 Each generator SHALL have states IDLE, SEND, GAPWAIT, DONE; reset state IDLE.
REQ-023 IDLE/DONE + start SHALL go to SEND next cycle, clearing seq, all counters, err, err_count; start in SEND/GAPWAIT is ignored.
REQ-024 A transfer SHALL occur on a cycle with tx_valid[i] & tx_ready[i]; tx_valid high and tx_data stable until then.
REQ-025 After transfer: seq+1, tx_count+1; if tx_count reaches num_pkts (num_pkts != 0) go DONE, else GAP==0 -> SEND next cycle with new packet, GAP>0 -> GAPWAIT for exactly GAP cycles then SEND.
REQ-026 Each port SHALL own a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seeded SEED ^ (i+1), stepped once per transfer.
REQ-027 Mode 0 dest = lfsr[7:0] mod NUM_PORTS; mode 1 dest = fixed_dest mod NUM_PORTS; mode 2 first dest (i+1) mod NUM_PORTS, +1 mod NUM_PORTS per transfer.
REQ-028 If excl_self and computed dest == i, dest SHALL become (i+1) mod NUM_PORTS (all modes).
REQ-029 mode, fixed_dest, excl_self, num_pkts SHALL be sampled only at start.
REQ-030 rx_ready SHALL be 1 in every cycle except reset; each rx_valid cycle counts one packet.
REQ-031 Received dest != i SHALL set err[i] and increment err_count in the same edge.
REQ-032 Counters SHALL saturate at 2^SEQ_W-1, never wrap; seq wraps modulo 2^SEQ_W.
REQ-033 all_done SHALL be registered, asserted the cycle after its condition holds; low when num_pkts == 0 during a run.

Reset
REQ-034 reset SHALL force IDLE, tx_valid=0, rx_ready=0, all counters/err/err_count/all_done=0, LFSRs reseeded, mode registers 0; reset mid-transfer discards the packet.
REQ-035 reset SHALL dominate start and rx_valid in the same cycle.

Verification
REQ-036 Mode 1, fixed_dest=5, num_pkts=3, tx_ready=1, loopback tx->rx at port 5 -> tx_count[p]=3 each port, rx_count[5]=39, err=0, all_done high.
REQ-037 Mode 2, excl_self=1, NUM_PORTS=13, port 12 -> dests 0,1,...; port 0 never emits dest 0.
REQ-038 tx_ready[3] low 10 cycles while valid -> tx_data[3] unchanged, tx_count[3] unchanged, then one transfer.
REQ-039 GAP=2, tx_ready=1 -> port valid pattern 1,0,0,1,0,0.
REQ-040 rx_valid[4] with dest 7 -> err[4]=1, err_count=1, persists until start/reset.
REQ-041 reset asserted mid-run with valids high -> next cycle all outputs zero, start then replays identical LFSR dest sequence.
